// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes, FSM states
// and the alignment rule used by the optional misaligned trap.
package load_store_unit_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    REQUEST   = 2'b01,
    WAIT_READ = 2'b10,
    DONE      = 2'b11
  } lsu_state_t;

  // Undefined encodings are word accesses, so they share the word rule.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      LSU_B, LSU_BU: is_misaligned = 1'b0;
      LSU_H, LSU_HU: is_misaligned = offset[0];
      default:       is_misaligned = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables, store replication, load shift and
// sign/zero extension. Halfwords use offset[1] only, words ignore the offset.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] write_data,
  input  logic [31:0] read_word,
  output logic [3:0]  byte_enable,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  logic [31:0] byte_shift;
  logic [15:0] half_sel;

  assign byte_shift = read_word >> {offset, 3'b000};
  assign half_sel   = offset[1] ? read_word[31:16] : read_word[15:0];

  always_comb begin
    byte_enable = 4'b1111;
    store_data  = write_data;
    load_data   = read_word;
    case (funct3)
      LSU_B, LSU_BU: begin
        byte_enable = 4'b0001 << offset;
        store_data  = {4{write_data[7:0]}};
        load_data   = (funct3 == LSU_B) ? {{24{byte_shift[7]}}, byte_shift[7:0]}
                                        : {24'h000000, byte_shift[7:0]};
      end
      LSU_H, LSU_HU: begin
        byte_enable = 4'b0011 << {offset[1], 1'b0};
        store_data  = {2{write_data[15:0]}};
        load_data   = (funct3 == LSU_H) ? {{16{half_sel[15]}}, half_sel}
                                        : {16'h0000, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit bridging the core's data port to a wait-stated word bus.
// Define LSU_MISALIGNED_TRAP_EN to fault misaligned accesses instead of issuing them.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int COUNTER_WIDTH  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        bus_error,
  output logic        misaligned_fault,
  output logic        bus_request,
  input  logic        bus_ready,
  output logic        bus_write,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_byte_enable,
  output logic [31:0] bus_write_data,
  input  logic        bus_read_valid,
  input  logic [31:0] bus_read_data
);

  lsu_state_t               state;
  logic [2:0]               funct3_q;
  logic [1:0]               offset_q;
  logic                     write_q;
  logic [COUNTER_WIDTH-1:0] counter;

  logic                     access_req;
  logic                     misaligned;
  logic                     timeout;
  logic [2:0]               sel_funct3;
  logic [1:0]               sel_offset;
  logic [3:0]               lane_be;
  logic [31:0]              lane_wd;
  logic [31:0]              lane_rd;

  assign access_req = read_enable | write_enable;
  assign stall      = access_req && (state != DONE);
  assign timeout    = (TIMEOUT_CYCLES != 0) && (counter == COUNTER_WIDTH'(TIMEOUT_CYCLES));

  // IDLE steers from the live request; later states use the latched access.
  assign sel_funct3 = (state == IDLE) ? funct3 : funct3_q;
  assign sel_offset = (state == IDLE) ? address[1:0] : offset_q;

`ifdef LSU_MISALIGNED_TRAP_EN
  assign misaligned = is_misaligned(funct3, address[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  lsu_lane_align u_lane_align (
    .funct3      (sel_funct3),
    .offset      (sel_offset),
    .write_data  (write_data),
    .read_word   (bus_read_data),
    .byte_enable (lane_be),
    .store_data  (lane_wd),
    .load_data   (lane_rd)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      funct3_q         <= 3'b000;
      offset_q         <= 2'b00;
      write_q          <= 1'b0;
      counter          <= '0;
      bus_request      <= 1'b0;
      bus_write        <= 1'b0;
      bus_address      <= 32'h0;
      bus_byte_enable  <= 4'h0;
      bus_write_data   <= 32'h0;
      read_data        <= 32'h0;
      bus_error        <= 1'b0;
      misaligned_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access_req) begin
            funct3_q <= funct3;
            offset_q <= address[1:0];
            write_q  <= write_enable;
            if (misaligned) begin
              misaligned_fault <= 1'b1;
              state            <= DONE;
            end else begin
              counter         <= '0;
              bus_request     <= 1'b1;
              bus_write       <= write_enable;
              bus_address     <= {address[31:2], 2'b00};
              bus_byte_enable <= lane_be;
              bus_write_data  <= lane_wd;
              state           <= REQUEST;
            end
          end
        end
        // A handshake in the same cycle as the timeout still completes normally.
        REQUEST: begin
          if (bus_ready) begin
            bus_request <= 1'b0;
            counter     <= counter + COUNTER_WIDTH'(1);
            state       <= write_q ? DONE : WAIT_READ;
          end else if (timeout) begin
            bus_request <= 1'b0;
            bus_error   <= 1'b1;
            state       <= DONE;
          end else begin
            counter <= counter + COUNTER_WIDTH'(1);
          end
        end
        WAIT_READ: begin
          if (bus_read_valid) begin
            read_data <= lane_rd;
            state     <= DONE;
          end else if (timeout) begin
            bus_error <= 1'b1;
            state     <= DONE;
          end else begin
            counter <= counter + COUNTER_WIDTH'(1);
          end
        end
        DONE: begin
          read_data        <= 32'h0;
          bus_error        <= 1'b0;
          misaligned_fault <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
